// File: rtl/seg7_calc_scan.sv
// Purpose: start/done arithmetic engine (pass, CLZ, CLMUL, cube root) with sequential BCD and a scanned 7-seg display.
// Latency: o_done is 3*DATA_W cycles after the start edge; it rises at the same edge that updates o_result.
// Backpressure: none; i_start is only sampled in IDLE and is ignored while the engine is busy.
module seg7_calc_scan #(
  parameter int DATA_W         = 8,
  parameter int DIGITS         = 4,
  parameter int REFRESH_W      = 18,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic [1:0]            i_mode,
  input  logic [DATA_W-1:0]     i_a,
  input  logic [DATA_W-1:0]     i_b,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [2*DATA_W-1:0]   o_result,
  output logic [DIGITS-1:0]     o_dig,
  output logic [7:0]            o_seg
);

  localparam int RES_W    = 2 * DATA_W;
  localparam int CUBE_W   = 3 * DATA_W;
  localparam int ROOT_W   = (DATA_W + 2) / 3;
  // ceil(RES_W * log10(2)) digits plus one spare, so the top nibble never overflows during add-3.
  localparam int BCD_DIG  = (RES_W * 302 + 999) / 1000 + 1;
  localparam int NDIG     = (BCD_DIG > DIGITS) ? BCD_DIG : DIGITS;
  localparam int BCD_W    = 4 * NDIG;
  localparam int CNT_W    = $clog2(RES_W);
  localparam int SEL_W    = $clog2(DIGITS);
  localparam int SCAN_W   = REFRESH_W + SEL_W;
  localparam int SCAN_MAX = DIGITS * (1 << REFRESH_W) - 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_BCD  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           mode_q, mode_d;
  logic [DATA_W-1:0]    a_q, a_d;
  logic [DATA_W-1:0]    b_q, b_d;
  logic [RES_W-1:0]     sh_q, sh_d;
  logic [RES_W-1:0]     acc_q, acc_d;
  logic [DATA_W-1:0]    rbit_q, rbit_d;
  logic                 found_q, found_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [RES_W-1:0]     bin_q, bin_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;
  logic [BCD_W-1:0]     disp_q, disp_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [RES_W-1:0]     result_q, result_d;
  logic [SCAN_W-1:0]    scan_q, scan_d;
  logic [DIGITS-1:0]    dig_q, dig_d;
  logic [7:0]           seg_q, seg_d;

  logic [DATA_W-1:0]    cand;
  logic [CUBE_W-1:0]    cand_w;
  logic [CUBE_W-1:0]    cube;
  logic [BCD_W-1:0]     bcd_adj;
  logic [BCD_W-1:0]     bcd_shift;

  logic [SEL_W-1:0]     sel;
  int                   sel_n;
  logic [3:0]           cur;
  logic                 nz;
  logic                 ovf;
  logic [7:0]           raw;

  // Register every piece of state; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      mode_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sh_q     <= '0;
      acc_q    <= '0;
      rbit_q   <= '0;
      found_q  <= 1'b0;
      cnt_q    <= '0;
      bin_q    <= '0;
      bcd_q    <= '0;
      disp_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      scan_q   <= '0;
      dig_q    <= '1;
      seg_q    <= (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sh_q     <= sh_d;
      acc_q    <= acc_d;
      rbit_q   <= rbit_d;
      found_q  <= found_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      disp_q   <= disp_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      scan_q   <= scan_d;
      dig_q    <= dig_d;
      seg_q    <= seg_d;
    end
  end

  // Next-state logic for the IDLE/CALC/BCD engine and its one-step-per-cycle datapath.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    a_d      = a_q;
    b_d      = b_q;
    sh_d     = sh_q;
    acc_d    = acc_q;
    rbit_d   = rbit_q;
    found_d  = found_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    disp_d   = disp_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;

    // Cube-root trial: candidate root with the current bit set, cubed at full width.
    cand   = acc_q[DATA_W-1:0] | rbit_q;
    cand_w = CUBE_W'(cand);
    cube   = cand_w * cand_w * cand_w;

    // Double-dabble: add 3 to every digit >= 5, then shift in the next binary MSB.
    bcd_adj = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end else begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
      end
    end
    bcd_shift = BCD_W'({bcd_adj, bin_q[RES_W-1]});

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          a_d     = i_a;
          b_d     = i_b;
          mode_d  = i_mode;
          sh_d    = RES_W'(i_a);
          acc_d   = (i_mode == 2'b00) ? RES_W'(i_a) : '0;
          rbit_d  = DATA_W'(1) << (ROOT_W - 1);
          found_d = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        case (mode_q)
          2'b01: begin
            // Count zeros from the MSB until the first one is seen.
            if (!found_q) begin
              if (sh_q[DATA_W-1]) begin
                found_d = 1'b1;
              end else begin
                acc_d = acc_q + RES_W'(1);
              end
            end
            sh_d = sh_q << 1;
          end
          2'b10: begin
            // Carry-less multiply: XOR in A<<i when bit i of B is set.
            if (b_q[0]) begin
              acc_d = acc_q ^ sh_q;
            end
            sh_d = sh_q << 1;
            b_d  = b_q >> 1;
          end
          2'b11: begin
            // Restoring cube root; once rbit runs out the remaining cycles idle.
            if ((rbit_q != '0) && (cube <= CUBE_W'(a_q))) begin
              acc_d = RES_W'(cand);
            end
            rbit_d = rbit_q >> 1;
          end
          default: begin
          end
        endcase
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          cnt_d   = '0;
          bin_d   = acc_d;
          bcd_d   = '0;
          state_d = S_BCD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_BCD: begin
        bcd_d = bcd_shift;
        bin_d = bin_q << 1;
        if (cnt_q == CNT_W'(RES_W - 1)) begin
          cnt_d    = '0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          result_d = acc_q;
          disp_d   = bcd_shift;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Display scan: pick the active digit, apply blanking/overflow/dp, then set polarity.
  always_comb begin
    scan_d = (scan_q == SCAN_W'(SCAN_MAX)) ? '0 : scan_q + SCAN_W'(1);
    sel    = scan_q[SCAN_W-1:REFRESH_W];
    sel_n  = int'(sel);

    cur = 4'd0;
    nz  = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (i == sel_n) begin
        cur = disp_q[4*i +: 4];
      end
      if ((i >= sel_n) && (disp_q[4*i +: 4] != 4'd0)) begin
        nz = 1'b1;
      end
    end

    ovf = 1'b0;
    for (int i = DIGITS; i < NDIG; i++) begin
      if (disp_q[4*i +: 4] != 4'd0) begin
        ovf = 1'b1;
      end
    end

    raw = 8'h00;
    if (ovf) begin
      raw = 8'h40;
    end else if ((sel_n != 0) && !nz) begin
      raw = 8'h00;
    end else begin
      case (cur)
        4'd0:    raw = 8'h3F;
        4'd1:    raw = 8'h06;
        4'd2:    raw = 8'h5B;
        4'd3:    raw = 8'h4F;
        4'd4:    raw = 8'h66;
        4'd5:    raw = 8'h6D;
        4'd6:    raw = 8'h7D;
        4'd7:    raw = 8'h07;
        4'd8:    raw = 8'h7F;
        4'd9:    raw = 8'h6F;
        default: raw = 8'h00;
      endcase
    end
    if (busy_q && (sel_n == 0)) begin
      raw[7] = 1'b1;
    end

    dig_d = ~(DIGITS'(1) << sel);
    seg_d = (SEG_ACTIVE_LOW != 0) ? ~raw : raw;
  end

  assign o_busy   = busy_q;
  assign o_done   = done_q;
  assign o_result = result_q;
  assign o_dig    = dig_q;
  assign o_seg    = seg_q;

endmodule
